uart_prog_wb: RTL

UART_PROG_WB -- requirements
Module: uart_prog_wb

---
 rtl/uart_prog_wb_if.sv | 22 ++
 rtl/uart_prog_wb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_wb_if.sv
// Wishbone pipelined master bundle for the UART-to-memory programmer.
interface uart_prog_wb_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_stall_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i, wbm_stall_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i, wbm_stall_i
  );
endinterface

// File: rtl/uart_prog_wb.sv
// Packs UART bytes little-endian into 32-bit words and writes them to
// consecutive Wishbone addresses; partial words are flushed on idle or disable.
module uart_prog_wb #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned IDLE_TIMEOUT = 200000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        prog_en_i,
  input  logic        uart_rx_irq,
  input  logic [7:0]  uart_rx_byte,
  uart_prog_wb_if.master wbm,
  output logic        done_o,
  output logic        busy_o,
  output logic [15:0] word_cnt_o,
  output logic        err_o
);

  typedef enum logic [2:0] {IDLE, COLLECT, REQ, WAIT_ACK, FLUSH_CHK, DONE} state_e;

  localparam logic [15:0] MEM_LIMIT = 16'(MEM_WORDS);
  localparam logic [31:0] IDLE_LAST = 32'(IDLE_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        en_prev_q;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [31:0] idle_q, idle_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        flush_q, flush_d;
  logic        en_rise, en_fall;
  logic        byte_vld;
  logic [7:0]  byte_val;

  assign en_rise = prog_en_i & ~en_prev_q;
  assign en_fall = ~prog_en_i & en_prev_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= IDLE;
      en_prev_q  <= 1'b1;  // a level already high at release is not an edge
      idx_q      <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      idle_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_prev_q  <= prog_en_i;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      idle_q     <= idle_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      flush_q    <= flush_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    data_d     = data_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    idle_d     = idle_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    flush_d    = flush_q;
    byte_vld   = 1'b0;
    byte_val   = uart_rx_byte;

    unique case (state_q)
      IDLE: begin
        if (en_rise) begin
          state_d    = COLLECT;
          idx_d      = '0;
          sel_d      = '0;
          data_d     = '0;
          hold_d     = '0;
          hold_vld_d = 1'b0;
          idle_d     = '0;
          cnt_d      = '0;
          err_d      = 1'b0;
          flush_d    = 1'b0;
        end
      end
      COLLECT: begin
        // A held byte is consumed first; a byte arriving alongside refills the holder.
        if (hold_vld_q) begin
          byte_vld   = 1'b1;
          byte_val   = hold_q;
          hold_vld_d = uart_rx_irq;
          hold_d     = uart_rx_irq ? uart_rx_byte : '0;
        end else if (uart_rx_irq) begin
          byte_vld = 1'b1;
        end
        if (byte_vld) begin
          idle_d                          = '0;
          data_d[{idx_q, 3'b000} +: 8]    = byte_val;
          sel_d[idx_q]                    = 1'b1;
          idx_d                           = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (cnt_q == MEM_LIMIT) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              state_d = REQ;
            end
          end else if (en_fall) begin
            state_d = FLUSH_CHK;
          end
        end else if (en_fall || idle_q == IDLE_LAST) begin
          state_d = FLUSH_CHK;
        end else begin
          idle_d = idle_q + 32'd1;
        end
      end
      REQ: begin
        if (!wbm.wbm_stall_i) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (wbm.wbm_err_i) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wbm.wbm_ack_i) begin
          cnt_d   = cnt_q + 16'd1;
          idx_d   = '0;
          sel_d   = '0;
          data_d  = '0;
          idle_d  = '0;
          flush_d = 1'b0;
          state_d = flush_q ? DONE : COLLECT;
        end
      end
      FLUSH_CHK: begin
        if (idx_q == 2'd0) begin
          state_d = DONE;
        end else if (cnt_q == MEM_LIMIT) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          flush_d = 1'b1;
          state_d = REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == REQ || state_q == WAIT_ACK) && uart_rx_irq) begin
      if (hold_vld_q) begin
        err_d = 1'b1;
      end else begin
        hold_d     = uart_rx_byte;
        hold_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    wbm.wbm_cyc_o = (state_q == REQ) || (state_q == WAIT_ACK);
    wbm.wbm_stb_o = (state_q == REQ);
    // Write-only master: we is high whenever the block is out of reset.
    wbm.wbm_we_o  = wb_rst_i;
    wbm.wbm_adr_o = wbm.wbm_cyc_o ? (BASE_ADDR + {14'b0, cnt_q, 2'b00}) : '0;
    wbm.wbm_dat_o = wbm.wbm_cyc_o ? data_q : '0;
    wbm.wbm_sel_o = wbm.wbm_cyc_o ? sel_q : '0;
  end

  assign done_o     = (state_q == DONE);
  assign busy_o     = (state_q != IDLE);
  assign word_cnt_o = cnt_q;
  assign err_o      = err_q;

endmodule
